gpio_apb_sequencer: RTL and testbench
=====================================

// Module: gpio_apb_sequencer
// PURPOSE
//  APB3 master that owns the CoreGPIO slave. After reset it programs CONFIG_0..CONFIG_{IO_NUM-1}
//  and clears the IRQ register. It then schedules two sources onto the single APB port:
//  a host command port (GPIO_OUT write / GPIO_IN read) and a periodic GPIO_IN poller.
//  Sits between the MiV-side control logic and the CoreGPIO instance.
// PARAMETERS
//  IO_NUM       2      GPIO count (1..32); number of CONFIG writes at init
//  IO_CFG       8'h07  value written to every CONFIG_n (out reg, in reg, out buffer enabled)
//  POLL_CYCLES  1000   PCLK cycles between poll requests (>=8)
//  TIMEOUT      255    max ACCESS-phase cycles with PREADY low before abort (1..255)
// PORTS
//  PCLK         in   1       clock
//  PRESET       in   1       synchronous active-high reset
//  PADDR        out  8       APB address
//  PSEL         out  1       APB select
//  PENABLE      out  1       APB enable
//  PWRITE       out  1       APB direction, 1=write
//  PWDATA       out  32      APB write data
//  PRDATA       in   32      APB read data
//  PREADY       in   1       APB ready
//  PSLVERR      in   1       APB slave error
//  cmd_valid    in   1       host command request
//  cmd_ready    out  1       command accepted when cmd_valid&cmd_ready
//  cmd_write    in   1       1=write GPIO_OUT, 0=read GPIO_IN
//  cmd_wdata    in   32      GPIO_OUT value
//  rsp_valid    out  1       one-cycle response strobe
//  rsp_rdata    out  32      read data (0 for writes)
//  rsp_err      out  1       PSLVERR or timeout on this transfer
//  in_state     out  32      last polled GPIO_IN value
//  poll_update  out  1       one-cycle strobe when in_state is updated
//  init_done    out  1       high once the init sequence has completed
// BEHAVIOUR
//  Reset (PRESET high at PCLK edge): all outputs 0, state=INIT, timer=POLL_CYCLES-1, poll_pending=0.
//    Reset asserted mid-transfer drops PSEL/PENABLE on the next edge and restarts the init sequence.
//  Address map: CONFIG_n=4*n, IRQ=8'h80, GPIO_IN=8'h90, GPIO_OUT=8'hA0.
//  States: INIT -> SETUP -> ACCESS -> (INIT|RESP) ; IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  INIT: issues writes CONFIG_0..CONFIG_{IO_NUM-1} with PWDATA=IO_CFG, then IRQ with 32'hFFFF_FFFF.
//    After the IRQ write completes, init_done=1 (sticky until reset) and the FSM enters IDLE.
//    Init PSLVERR or timeout is ignored; the sequence always proceeds. Commands and polls wait.
//  SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid; lasts exactly one cycle.
//  ACCESS: PSEL=1, PENABLE=1, signals held; completes on the first cycle with PREADY=1.
//    Capture PRDATA and PSLVERR on that cycle.
//    If PREADY stays low for TIMEOUT cycles, the transfer ends with err=1 and rdata=0.
//  cmd_ready=1 only in IDLE with init_done=1. Arbitration in IDLE: cmd_valid beats
//    poll_pending; a poll is never dropped, it is serviced at the next IDLE without cmd_valid.
//  Command latency: accept at cycle T, SETUP at T+1, ACCESS at T+2,
//    rsp_valid pulses at T+3 when PREADY=1 at T+2 (plus N wait cycles).
//  Polls: a poll read of 8'h90 gives in_state<=PRDATA and a poll_update pulse in the RESP cycle.
//    On error, in_state is held and poll_update is still pulsed. Polls never raise rsp_valid.
//  Poll timer runs only while init_done=1. It counts down each cycle; on 0 it reloads
//    POLL_CYCLES-1 and sets poll_pending. If a poll is already pending, the pending flag stays
//    set (expiries coalesce). Servicing a poll clears poll_pending at SETUP entry.
//  RESP: one cycle, PSEL=0, then IDLE. Back-to-back commands are accepted at best every 4 cycles.
// TESTING
//  1 Reset, IO_NUM=2, PREADY=1: writes 00<-07, 04<-07, 80<-FFFFFFFF, each 2 cycles;
//    init_done rises after the 3rd.
//  2 Cmd write 32'h3 with PREADY=1: PADDR=A0 and PWDATA=3 in SETUP; rsp_valid 3 cycles after
//    accept, with rsp_err=0 and rsp_rdata=0.
//  3 Cmd read with PREADY low 2 cycles and PRDATA=32'h2: rsp_valid 5 cycles after accept,
//    with rsp_rdata=2.
//  4 POLL_CYCLES=8 with cmd_valid held high: commands win every IDLE. Drop cmd_valid: exactly
//    one poll issues, and in_state updates with a single poll_update pulse.
//  5 PREADY stuck low, TIMEOUT=4: ACCESS lasts 4 cycles; rsp_err=1, rsp_rdata=0; FSM returns to IDLE.
//  6 PRESET pulsed during command ACCESS: PSEL=0 next cycle, no rsp_valid, init restarts at CONFIG_0.

Source files
------------

// File: rtl/gpio_apb_sequencer.sv
// APB3 master for the CoreGPIO slave: programs CONFIG_n and clears IRQ after reset,
// then arbitrates host GPIO commands against a periodic GPIO_IN poll on one APB port.
//
//   state  | meaning
//   INIT   | choose the next init write (CONFIG_n, then IRQ) or finish init
//   SETUP  | APB setup phase, PSEL=1 PENABLE=0
//   ACCESS | APB access phase, wait for PREADY or the timeout counter
//   RESP   | one-cycle response / poll_update strobe, bus idle
//   IDLE   | accept a host command, else service a pending poll
module gpio_apb_sequencer #(
    parameter int         IO_NUM      = 2,
    parameter logic [7:0] IO_CFG      = 8'h07,
    parameter int         POLL_CYCLES = 1000,
    parameter int         TIMEOUT     = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    output logic [7:0]  PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] in_state,
    output logic        poll_update,
    output logic        init_done
);

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_ACCESS = 3'd2;
    localparam logic [2:0] S_RESP   = 3'd3;
    localparam logic [2:0] S_IDLE   = 3'd4;

    localparam logic [7:0] A_IRQ      = 8'h80;
    localparam logic [7:0] A_GPIO_IN  = 8'h90;
    localparam logic [7:0] A_GPIO_OUT = 8'hA0;

    localparam int            TW          = $clog2(POLL_CYCLES);
    localparam logic [TW-1:0] POLL_RELOAD = TW'(POLL_CYCLES - 1);
    localparam logic [7:0]    TO_LOAD     = 8'(TIMEOUT - 1);
    localparam logic [5:0]    IDX_IRQ     = 6'(IO_NUM);
    localparam logic [5:0]    IDX_DONE    = 6'(IO_NUM + 1);

    logic [2:0]    state_q, state_d;
    logic [5:0]    idx_q, idx_d;
    logic [7:0]    paddr_q, paddr_d;
    logic          pwrite_q, pwrite_d;
    logic [31:0]   pwdata_q, pwdata_d;
    logic          poll_q, poll_d;
    logic [7:0]    wait_q, wait_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [31:0]   in_state_q, in_state_d;
    logic          init_done_q, init_done_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pend_q, pend_d;
    logic          xfer_end, xfer_err;
    logic [31:0]   xfer_rdata;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        poll_d      = poll_q;
        wait_d      = wait_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        in_state_d  = in_state_q;
        init_done_d = init_done_q;
        timer_d     = timer_q;
        pend_d      = pend_q;
        xfer_end    = 1'b0;
        xfer_err    = 1'b0;
        xfer_rdata  = '0;

        case (state_q)
            S_INIT: begin
                pwrite_d = 1'b1;
                poll_d   = 1'b0;
                if (idx_q == IDX_DONE) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (idx_q == IDX_IRQ) begin
                    paddr_d  = A_IRQ;
                    pwdata_d = 32'hFFFF_FFFF;
                    state_d  = S_SETUP;
                end else begin
                    paddr_d  = {idx_q, 2'b00};
                    pwdata_d = {24'd0, IO_CFG};
                    state_d  = S_SETUP;
                end
            end
            S_SETUP: begin
                wait_d  = TO_LOAD;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    xfer_end   = 1'b1;
                    xfer_err   = PSLVERR;
                    xfer_rdata = pwrite_q ? 32'd0 : PRDATA;
                end else if (wait_q == 8'd0) begin
                    xfer_end = 1'b1;
                    xfer_err = 1'b1;
                end else begin
                    wait_d = wait_q - 8'd1;
                end
                // Init errors are deliberately dropped: the sequence always advances.
                if (xfer_end) begin
                    rdata_d = xfer_rdata;
                    err_d   = xfer_err;
                    if (!init_done_q) begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_INIT;
                    end else begin
                        state_d = S_RESP;
                        if (poll_q && !xfer_err) in_state_d = xfer_rdata;
                    end
                end
            end
            S_RESP: state_d = S_IDLE;
            S_IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_write ? A_GPIO_OUT : A_GPIO_IN;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : 32'd0;
                    poll_d   = 1'b0;
                    state_d  = S_SETUP;
                end else if (pend_q) begin
                    paddr_d  = A_GPIO_IN;
                    pwrite_d = 1'b0;
                    pwdata_d = 32'd0;
                    poll_d   = 1'b1;
                    pend_d   = 1'b0;
                    state_d  = S_SETUP;
                end
            end
            default: state_d = S_INIT;
        endcase

        // Evaluated after the IDLE clear so an expiry in the same cycle is not lost.
        if (init_done_q) begin
            if (timer_q == '0) begin
                timer_d = POLL_RELOAD;
                pend_d  = 1'b1;
            end else begin
                timer_d = timer_q - TW'(1);
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= S_INIT;
            idx_q       <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            poll_q      <= 1'b0;
            wait_q      <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            in_state_q  <= '0;
            init_done_q <= 1'b0;
            timer_q     <= POLL_RELOAD;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            poll_q      <= poll_d;
            wait_q      <= wait_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            in_state_q  <= in_state_d;
            init_done_q <= init_done_d;
            timer_q     <= timer_d;
            pend_q      <= pend_d;
        end
    end

    assign PSEL        = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign PENABLE     = (state_q == S_ACCESS);
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign cmd_ready   = (state_q == S_IDLE) && init_done_q;
    assign rsp_valid   = (state_q == S_RESP) && !poll_q;
    assign poll_update = (state_q == S_RESP) && poll_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign in_state    = in_state_q;
    assign init_done   = init_done_q;

endmodule

// File: tb/tb_gpio_apb_sequencer.sv
// Bench for gpio_apb_sequencer: responsive APB slave with per-transfer wait/data/error,
// and a response model built from transfer outcomes (latency, timeout, poll coalescing).
module tb_gpio_apb_sequencer;

    localparam int TB_IO   = 2;
    localparam int TB_POLL = 8;
    localparam int TB_TO   = 4;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic [31:0] obs_in;
        logic [31:0] exp_in;
        int          obs_cyc;
        int          exp_cyc;
        logic [7:0]  addr;
        logic        wr;
    } poll_t;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic [7:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_err, poll_update, init_done;
    logic [31:0] rsp_rdata, in_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_cmd = 0;
    int n_rsp = 0;

    int          k_w = 0;
    logic [31:0] k_d = '0;
    logic        k_e = 1'b0;

    xfer_t       xq[$];
    poll_t       pq[$];
    xfer_t       cur;
    int          cur_setup = 0;
    int          cur_w = 0;
    logic [31:0] cur_d = '0;
    logic        cur_e = 1'b0;
    int          acc_cnt = 0;
    logic [31:0] ref_in = '0;

    gpio_apb_sequencer #(
        .IO_NUM(TB_IO), .IO_CFG(8'h07), .POLL_CYCLES(TB_POLL), .TIMEOUT(TB_TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .in_state(in_state), .poll_update(poll_update), .init_done(init_done)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    // Slave and poll reference: each transfer takes the knobs current at its SETUP.
    always @(negedge PCLK) begin
        poll_t p;
        int    acc;
        bit    ok;
        if (poll_update) begin
            ok        = (cur_w + 1 <= TB_TO) && !cur_e;
            acc       = (cur_w + 1 < TB_TO) ? cur_w + 1 : TB_TO;
            p.obs_in  = in_state;
            p.exp_in  = ok ? cur_d : ref_in;
            p.obs_cyc = cyc;
            p.exp_cyc = cur_setup + 1 + acc;
            p.addr    = cur.addr;
            p.wr      = cur.wr;
            ref_in    = p.exp_in;
            pq.push_back(p);
        end
        if (rsp_valid) n_rsp++;
        if (PRESET) ref_in = '0;
        if (PSEL && !PENABLE) begin
            cur.addr  = PADDR;
            cur.wr    = PWRITE;
            cur.wdata = PWDATA;
            cur_setup = cyc;
            cur_w     = k_w;
            cur_d     = k_d;
            cur_e     = k_e;
            acc_cnt   = 0;
            xq.push_back(cur);
        end
        if (PSEL && PENABLE) begin
            if (acc_cnt == cur_w) begin
                PREADY  = 1'b1;
                PRDATA  = cur_d;
                PSLVERR = cur_e;
            end else begin
                PREADY  = 1'b0;
                PRDATA  = $urandom;
                PSLVERR = 1'($urandom);
            end
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            PRDATA  = $urandom;
            PSLVERR = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_init();
        bit got = 0;
        xfer_t x;
        for (int n = 0; n < 60; n++) begin
            if (init_done) begin
                got = 1;
                break;
            end
            @(negedge PCLK);
        end
        chk("init_done_seen", 32'(got), 32'd1);
        chk("init_xfer_count", 32'(xq.size()), 32'(TB_IO + 1));
        for (int i = 0; i < xq.size() && i <= TB_IO; i++) begin
            x = xq[i];
            chk("init_addr", 32'(x.addr), (i == TB_IO) ? 32'h80 : 32'(4 * i));
            chk("init_wdata", x.wdata, (i == TB_IO) ? 32'hFFFF_FFFF : 32'h07);
            chk("init_pwrite", 32'(x.wr), 32'd1);
        end
    endtask

    task automatic do_cmd(input logic wr, input logic [31:0] wd, input int w,
                          input logic [31:0] d, input logic e);
        bit got = 0;
        int t_acc = 0;
        int nacc = 0;
        int acc_exp;
        bit tmo;
        k_w = w;
        k_d = d;
        k_e = e;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_wdata = wd;
        for (int n = 0; n < 40; n++) begin
            if (cmd_ready) begin
                got = 1;
                t_acc = cyc;
                break;
            end
            @(negedge PCLK);
        end
        chk("cmd_accept", 32'(got), 32'd1);
        @(negedge PCLK);
        cmd_valid = 1'b0;
        chk("setup_psel", 32'(PSEL), 32'd1);
        chk("setup_penable", 32'(PENABLE), 32'd0);
        chk("setup_paddr", 32'(PADDR), wr ? 32'hA0 : 32'h90);
        chk("setup_pwrite", 32'(PWRITE), 32'(wr));
        if (wr) chk("setup_pwdata", PWDATA, wd);
        got = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge PCLK);
            if (rsp_valid) begin
                got = 1;
                break;
            end
            if (PENABLE) nacc++;
        end
        tmo     = (w + 1 > TB_TO);
        acc_exp = tmo ? TB_TO : w + 1;
        chk("rsp_seen", 32'(got), 32'd1);
        chk("rsp_latency", 32'(cyc - t_acc), 32'(2 + acc_exp));
        chk("access_len", 32'(nacc), 32'(acc_exp));
        chk("rsp_err", 32'(rsp_err), tmo ? 32'd1 : 32'(e));
        chk("rsp_rdata", rsp_rdata, (tmo || wr) ? 32'd0 : d);
        n_cmd++;
    endtask

    task automatic drain_polls(output int cnt);
        poll_t p;
        cnt = 0;
        while (pq.size() > 0) begin
            p = pq.pop_front();
            chk("poll_in_state", p.obs_in, p.exp_in);
            chk("poll_cycle", 32'(p.obs_cyc), 32'(p.exp_cyc));
            chk("poll_addr", 32'(p.addr), 32'h90);
            chk("poll_pwrite", 32'(p.wr), 32'd0);
            cnt++;
        end
    endtask

    initial begin
        int  acc, hp, hr, win, dn;
        bit  got;
        PRESET    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_wdata = '0;
        repeat (3) @(negedge PCLK);
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", PWDATA, 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_poll_update", 32'(poll_update), 32'd0);
        chk("rst_in_state", in_state, 32'd0);
        xq.delete();
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("init_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("init_done_early", 32'(init_done), 32'd0);
        check_init();

        do_cmd(1'b1, 32'h3, 0, $urandom, 1'b0);
        do_cmd(1'b0, 32'h0, 2, 32'h2, 1'b0);
        do_cmd(1'b0, 32'h0, 1, 32'hDEAD_BEEF, 1'b1);
        do_cmd(1'b0, 32'h0, TB_TO - 1, 32'h1234_5678, 1'b0);
        do_cmd(1'b0, 32'h0, 10, 32'hCAFE_F00D, 1'b0);
        @(negedge PCLK);
        chk("timeout_back_to_idle", 32'(cmd_ready), 32'd1);
        drain_polls(dn);

        // Commands held continuously: every IDLE goes to a command, polls coalesce.
        k_w = 0;
        k_d = $urandom;
        k_e = 1'b0;
        got = 0;
        for (int n = 0; n < 40; n++) begin
            if (cmd_ready) begin
                got = 1;
                break;
            end
            @(negedge PCLK);
        end
        chk("hold_idle_seen", 32'(got), 32'd1);
        drain_polls(dn);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_wdata = $urandom;
        acc = 0;
        hp = 0;
        hr = 0;
        for (int i = 0; i < 48; i++) begin
            if (cmd_ready) acc++;
            hp += 32'(poll_update);
            hr += 32'(rsp_valid);
            @(negedge PCLK);
        end
        cmd_valid = 1'b0;
        chk("hold_accepts", 32'(acc), 32'd12);
        chk("hold_rsps", 32'(hr), 32'd12);
        chk("hold_no_polls", 32'(hp), 32'd0);
        n_cmd += acc;
        win = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge PCLK);
            win += 32'(poll_update);
        end
        chk("drop_single_poll", 32'(win), 32'd1);
        chk("drop_in_state", in_state, k_d);
        drain_polls(dn);
        chk("drop_poll_logged", 32'(dn), 32'd1);

        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 10)) @(negedge PCLK);
            do_cmd(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5), $urandom,
                   1'($urandom_range(0, 3) == 0));
        end
        repeat (20) @(negedge PCLK);
        drain_polls(dn);
        chk("random_polls_seen", 32'(dn > 0), 32'd1);

        // Reset in the middle of a command ACCESS phase.
        k_w = 20;
        got = 0;
        for (int n = 0; n < 40; n++) begin
            if (cmd_ready) begin
                got = 1;
                break;
            end
            @(negedge PCLK);
        end
        chk("mid_idle_seen", 32'(got), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        @(negedge PCLK);
        chk("mid_in_access", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("mid_rst_psel", 32'(PSEL), 32'd0);
        chk("mid_rst_penable", 32'(PENABLE), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_init_done", 32'(init_done), 32'd0);
        chk("mid_rst_in_state", in_state, 32'd0);
        xq.delete();
        k_w = 0;
        PRESET = 1'b0;
        check_init();
        repeat (5) @(negedge PCLK);
        chk("rsp_total", 32'(n_rsp), 32'(n_cmd));
        drain_polls(dn);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
